// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: an FSM that sequences the datapath strobes
// for R-type, lw, sw, beq, addi and j, and counts retired instructions.
module multicycle_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          OP,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSrc,
    output logic [2:0]          ALUop,
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t              r_state;
    logic [RETIRE_W-1:0] r_retired;
    logic                w_op_ok;

    assign w_op_ok = (OP == OP_R) || (OP == OP_LW) || (OP == OP_SW) ||
                     (OP == OP_BEQ) || (OP == OP_ADDI) || (OP == OP_J);

    // Retirement is counted on the edge that leaves an instruction's last state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (OP)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (OP == OP_LW)      r_state <= S_MEMRD;
                    else if (OP == OP_SW) r_state <= S_MEMWR;
                    else                  r_state <= S_FETCH;
                end
                S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR: begin
                    if (mem_ready) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + 1'b1;
                    end
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + 1'b1;
                end
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode straight from the state so reset clears them without a clock.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        ALUop       = 3'b000;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = !w_op_ok;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 3'b010;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 3'b001;
                PCSrc       = 2'b01;
                PCWriteCond = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule
